// File: rtl/irq_priority_arbiter.sv
// irq_priority_arbiter
//   Collects level interrupt lines from NUM_SRC peripherals. A rising edge on a
//   line sets its pending bit. One enabled pending source at a time is
//   presented to the core as a one-hot vector plus an ID (ID_BASE + index).
//   An acknowledge carrying the matching ID retires the interrupt. It is
//   followed by a one-cycle GAP before the next interrupt may be presented.
//
//   Compile-time option: define IRQ_ROUND_ROBIN_EN to rotate priority. The
//   search starts just above the last acknowledged source. When the macro is
//   undefined, the lowest index always wins.
//
// Ports
//   clk_i        clock, rising edge
//   rst_n_i      asynchronous active-low reset
//   irq_i        level interrupt lines (synchronous to clk_i)
//   cfg_we_i     config write strobe
//   cfg_addr_i   0=ENABLE, 1=PENDING (write-1-to-clear), 2=STATUS
//   cfg_wdata_i  config write data
//   cfg_rdata_o  registered read data for cfg_addr_i
//   irq_o        one-hot core interrupt vector (bit irq_id_o)
//   irq_id_o     presented interrupt ID, 0 when none
//   irq_ack_i    core acknowledge strobe
//   irq_id_i     ID being acknowledged
module irq_priority_arbiter #(
  parameter int NUM_SRC = 8,
  parameter int ID_BASE = 16
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic [NUM_SRC-1:0] irq_i,
  input  logic               cfg_we_i,
  input  logic [1:0]         cfg_addr_i,
  input  logic [31:0]        cfg_wdata_i,
  output logic [31:0]        cfg_rdata_o,
  output logic [31:0]        irq_o,
  output logic [4:0]         irq_id_o,
  input  logic               irq_ack_i,
  input  logic [4:0]         irq_id_i
);

  localparam int SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam logic [1:0] ADDR_ENABLE  = 2'd0;
  localparam logic [1:0] ADDR_PENDING = 2'd1;
  localparam logic [1:0] ADDR_STATUS  = 2'd2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
    GAP     = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [NUM_SRC-1:0] irq_prev_p0;
  logic               armed_p0;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] enable_q, enable_d;
  logic [NUM_SRC-1:0] edge_det, w1c_mask, ack_mask, cand;
  logic [SRC_W-1:0]   sel_q, sel_d, win_idx;
  logic               win_vld;
  logic [4:0]         id_d;
  logic [31:0]        vec_d;
  logic               ack_hit;

  // Edge-detect stage: irq_prev_p0 holds last cycle's lines. armed_p0 masks
  // the first cycle after reset, so that lines already high at release do not
  // count as edges.
  assign edge_det = armed_p0 ? (irq_i & ~irq_prev_p0) : '0;

  assign w1c_mask = (cfg_we_i && (cfg_addr_i == ADDR_PENDING)) ?
                    cfg_wdata_i[NUM_SRC-1:0] : '0;
  assign enable_d = (cfg_we_i && (cfg_addr_i == ADDR_ENABLE)) ?
                    cfg_wdata_i[NUM_SRC-1:0] : enable_q;

  assign ack_hit  = (state_q == PRESENT) && irq_ack_i && (irq_id_i == irq_id_o);
  assign ack_mask = ack_hit ? (NUM_SRC'(1) << sel_q) : '0;

  // A new edge is OR-ed in after the clears, so it survives a simultaneous
  // ack or W1C write.
  assign pending_d = (pending_q & ~(w1c_mask | ack_mask)) | edge_det;
  assign cand      = pending_q & enable_q;

`ifdef IRQ_ROUND_ROBIN_EN
  logic [SRC_W-1:0] last_q;

  always_comb begin
    int start;
    int k;
    win_vld = 1'b0;
    win_idx = '0;
    start   = (int'(last_q) + 1) % NUM_SRC;
    k       = 0;
    for (int i = 0; i < NUM_SRC; i++) begin
      k = (start + i) % NUM_SRC;
      if (!win_vld && cand[k]) begin
        win_vld = 1'b1;
        win_idx = SRC_W'(k);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      last_q <= SRC_W'(NUM_SRC - 1);
    end else if (ack_hit) begin
      last_q <= sel_q;
    end
  end
`else
  // The scan runs downward, so the lowest candidate index is the last one
  // assigned and therefore wins.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (cand[i]) begin
        win_vld = 1'b1;
        win_idx = SRC_W'(i);
      end
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    id_d    = irq_id_o;
    vec_d   = irq_o;
    case (state_q)
      IDLE: begin
        if (win_vld) begin
          state_d = PRESENT;
          sel_d   = win_idx;
          id_d    = 5'(ID_BASE + int'(win_idx));
          vec_d   = 32'd1 << id_d;
        end
      end
      PRESENT: begin
        if (ack_hit) begin
          state_d = GAP;
          id_d    = '0;
          vec_d   = '0;
        end else if (!enable_d[sel_q] || !pending_d[sel_q]) begin
          // Software disabled or cleared the presented source. Withdraw it
          // in the same edge as the write.
          state_d = IDLE;
          id_d    = '0;
          vec_d   = '0;
        end
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        id_d    = '0;
        vec_d   = '0;
      end
    endcase
  end

  // Register stage: FSM, pending/enable, outputs and read data
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      irq_prev_p0 <= '0;
      armed_p0    <= 1'b0;
      pending_q   <= '0;
      enable_q    <= '0;
      sel_q       <= '0;
      irq_id_o    <= '0;
      irq_o       <= '0;
      cfg_rdata_o <= '0;
    end else begin
      state_q     <= state_d;
      irq_prev_p0 <= irq_i;
      armed_p0    <= 1'b1;
      pending_q   <= pending_d;
      enable_q    <= enable_d;
      sel_q       <= sel_d;
      irq_id_o    <= id_d;
      irq_o       <= vec_d;
      case (cfg_addr_i)
        ADDR_ENABLE:  cfg_rdata_o <= 32'(enable_q);
        ADDR_PENDING: cfg_rdata_o <= 32'(pending_q);
        ADDR_STATUS:  cfg_rdata_o <= {19'd0, irq_id_o, 6'd0, state_q};
        default:      cfg_rdata_o <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_irq_priority_arbiter.sv
module tb_irq_priority_arbiter;

  localparam int K_ID = 0;
  localparam int K_RD = 1;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic [7:0]  irq_i = '0;
  logic        cfg_we_i = 1'b0;
  logic [1:0]  cfg_addr_i = '0;
  logic [31:0] cfg_wdata_i = '0;
  logic [31:0] cfg_rdata_o;
  logic [31:0] irq_o;
  logic [4:0]  irq_id_o;
  logic        irq_ack_i = 1'b0;
  logic [4:0]  irq_id_i = '0;

  irq_priority_arbiter #(.NUM_SRC(8), .ID_BASE(16)) dut (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .irq_i       (irq_i),
    .cfg_we_i    (cfg_we_i),
    .cfg_addr_i  (cfg_addr_i),
    .cfg_wdata_i (cfg_wdata_i),
    .cfg_rdata_o (cfg_rdata_o),
    .irq_o       (irq_o),
    .irq_id_o    (irq_id_o),
    .irq_ack_i   (irq_ack_i),
    .irq_id_i    (irq_id_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int          cyc;
    int          kind;
    string       name;
    logic [31:0] val;
  } exp_t;

  typedef struct {
    int          src;
    logic [7:0]  en;
    logic [4:0]  id;
    logic [31:0] pend;
    logic [31:0] stat;
  } vec_t;

  exp_t sb[$];
  vec_t vt[5];
  int   rr_exp[4];
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;

  function automatic void check(string nm, logic [31:0] act, logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
  endfunction

  task automatic push_exp(int d, int kind, string nm, logic [31:0] v);
    exp_t e;
    e.cyc  = cyc + d;
    e.kind = kind;
    e.name = nm;
    e.val  = v;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    logic [31:0] ev;
    for (int i = 0; i < sb.size(); ) begin
      if (sb[i].cyc == cyc) begin
        e = sb[i];
        sb.delete(i);
        if (e.kind == K_ID) begin
          ev = (e.val[4:0] == 5'd0) ? 32'd0 : (32'd1 << e.val[4:0]);
          check({e.name, "_id"}, {27'd0, irq_id_o}, e.val);
          check({e.name, "_vec"}, irq_o, ev);
        end else begin
          check(e.name, cfg_rdata_o, e.val);
        end
      end else begin
        i++;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
    cyc++;
    drain();
  endtask

  task automatic cfg_write(logic [1:0] a, logic [31:0] d);
    cfg_we_i    = 1'b1;
    cfg_addr_i  = a;
    cfg_wdata_i = d;
    tick();
    cfg_we_i    = 1'b0;
  endtask

  task automatic do_ack(logic [4:0] id);
    irq_ack_i = 1'b1;
    irq_id_i  = id;
    tick();
    irq_ack_i = 1'b0;
  endtask

  initial begin
    vt[0] = '{src: 3, en: 8'hFF, id: 5'd19, pend: 32'h00, stat: 32'h2};
    vt[1] = '{src: 0, en: 8'hFF, id: 5'd16, pend: 32'h00, stat: 32'h2};
    vt[2] = '{src: 7, en: 8'hFF, id: 5'd23, pend: 32'h00, stat: 32'h2};
    vt[3] = '{src: 4, en: 8'hEF, id: 5'd0,  pend: 32'h10, stat: 32'h0};
    vt[4] = '{src: 6, en: 8'h40, id: 5'd22, pend: 32'h00, stat: 32'h2};
`ifdef IRQ_ROUND_ROBIN_EN
    rr_exp = '{16, 17, 16, 17};
`else
    rr_exp = '{16, 16, 16, 16};
`endif

    // Reset values
    #1;
    check("rst_id", {27'd0, irq_id_o}, 32'd0);
    check("rst_vec", irq_o, 32'd0);
    check("rst_rdata", cfg_rdata_o, 32'd0);
    tick();
    tick();
    rst_n_i = 1'b1;
    tick();

    // Table-driven single-source vectors
    for (int v = 0; v < 5; v++) begin
      cfg_write(2'd0, {24'd0, vt[v].en});
      irq_i[vt[v].src] = 1'b1;
      push_exp(1, K_ID, $sformatf("v%0d_lat1", v), 32'd0);
      push_exp(2, K_ID, $sformatf("v%0d_lat2", v), {27'd0, vt[v].id});
      tick();
      irq_i = '0;
      tick();
      if (vt[v].id != 5'd0) begin
        push_exp(1, K_ID, $sformatf("v%0d_ack", v), 32'd0);
        do_ack(vt[v].id);
      end
      cfg_addr_i = 2'd2;
      push_exp(1, K_RD, $sformatf("v%0d_status", v), vt[v].stat);
      tick();
      cfg_addr_i = 2'd1;
      push_exp(1, K_RD, $sformatf("v%0d_pend", v), vt[v].pend);
      tick();
      cfg_write(2'd1, 32'hFF);
      tick();
    end

    // Two sources together, then mismatched ack and disable withdrawal
    cfg_write(2'd0, 32'hFF);
    cfg_addr_i = 2'd0;
    push_exp(1, K_RD, "en_rd", 32'hFF);
    irq_i = 8'h24;
    push_exp(2, K_ID, "pair_first", 32'd18);
    tick();
    irq_i = '0;
    tick();
    push_exp(1, K_ID, "pair_ack", 32'd0);
    push_exp(2, K_ID, "pair_gap", 32'd0);
    push_exp(3, K_ID, "pair_second", 32'd21);
    do_ack(5'd18);
    tick();
    tick();
    cfg_addr_i = 2'd2;
    push_exp(1, K_ID, "bad_ack", 32'd21);
    push_exp(1, K_RD, "status_present", 32'h1501);
    do_ack(5'd18);
    push_exp(1, K_ID, "disable_withdraw", 32'd0);
    cfg_write(2'd0, 32'h00);
    cfg_addr_i = 2'd2;
    push_exp(1, K_RD, "status_idle", 32'd0);
    tick();
    cfg_addr_i = 2'd1;
    push_exp(1, K_RD, "pend5_kept", 32'h20);
    tick();
    cfg_write(2'd1, 32'h20);
    push_exp(1, K_RD, "pend5_cleared", 32'h00);
    tick();
    cfg_write(2'd0, 32'hFF);

    // Edge in the ack cycle keeps pending set
    irq_i[1] = 1'b1;
    push_exp(2, K_ID, "reedge_first", 32'd17);
    tick();
    irq_i = '0;
    tick();
    irq_i[1] = 1'b1;
    push_exp(1, K_ID, "reedge_ack", 32'd0);
    push_exp(2, K_ID, "reedge_gap", 32'd0);
    push_exp(3, K_ID, "reedge_again", 32'd17);
    do_ack(5'd17);
    irq_i = '0;
    tick();
    tick();
    cfg_addr_i = 2'd1;
    push_exp(1, K_RD, "reedge_pend", 32'h02);
    tick();
    push_exp(1, K_ID, "reedge_ack2", 32'd0);
    do_ack(5'd17);
    tick();
    tick();

    // Presented ID holds while a higher-priority source arrives
    irq_i[6] = 1'b1;
    push_exp(2, K_ID, "hold_first", 32'd22);
    tick();
    irq_i = '0;
    tick();
    irq_i[0] = 1'b1;
    push_exp(1, K_ID, "hold_1", 32'd22);
    push_exp(2, K_ID, "hold_2", 32'd22);
    tick();
    irq_i = '0;
    tick();
    push_exp(1, K_ID, "hold_ack", 32'd0);
    push_exp(3, K_ID, "hold_next", 32'd16);
    do_ack(5'd22);
    tick();
    tick();
    push_exp(1, K_ID, "hold_ack2", 32'd0);
    do_ack(5'd16);
    tick();
    tick();

    // W1C on the presented source withdraws it
    irq_i[4] = 1'b1;
    push_exp(2, K_ID, "w1c_first", 32'd20);
    tick();
    irq_i = '0;
    tick();
    push_exp(1, K_ID, "w1c_withdraw", 32'd0);
    cfg_write(2'd1, 32'h10);
    cfg_addr_i = 2'd2;
    push_exp(1, K_RD, "w1c_status", 32'd0);
    tick();
    tick();

    // Grant order with sources 0 and 1 re-pulsed on every ack
    cfg_write(2'd0, 32'h03);
    irq_i = 8'h03;
    push_exp(2, K_ID, "rr_g0", rr_exp[0]);
    tick();
    irq_i = '0;
    tick();
    for (int g = 1; g < 4; g++) begin
      irq_i = 8'h03;
      push_exp(1, K_ID, $sformatf("rr_ack%0d", g), 32'd0);
      push_exp(3, K_ID, $sformatf("rr_g%0d", g), rr_exp[g]);
      do_ack(5'(rr_exp[g-1]));
      irq_i = '0;
      tick();
      tick();
    end
    push_exp(1, K_ID, "rr_ack_last", 32'd0);
    do_ack(5'(rr_exp[3]));
    cfg_write(2'd1, 32'hFF);
    push_exp(1, K_ID, "rr_quiet", 32'd0);
    tick();

    // Asynchronous reset mid-presentation, lines held high through release
    cfg_write(2'd0, 32'hFF);
    irq_i[4] = 1'b1;
    push_exp(2, K_ID, "arst_first", 32'd20);
    tick();
    tick();
    irq_i = 8'hFF;
    #2;
    rst_n_i = 1'b0;
    #1;
    check("arst_id", {27'd0, irq_id_o}, 32'd0);
    check("arst_vec", irq_o, 32'd0);
    tick();
    check("arst_rdata", cfg_rdata_o, 32'd0);
    tick();
    rst_n_i = 1'b1;
    cfg_addr_i = 2'd0;
    push_exp(1, K_RD, "arst_enable", 32'd0);
    tick();
    cfg_write(2'd0, 32'hFF);
    cfg_addr_i = 2'd1;
    push_exp(1, K_ID, "arst_none1", 32'd0);
    push_exp(2, K_ID, "arst_none2", 32'd0);
    push_exp(3, K_ID, "arst_none3", 32'd0);
    push_exp(3, K_RD, "arst_pend", 32'd0);
    tick();
    tick();
    tick();
    irq_i = '0;
    tick();

    while (sb.size() > 0) begin
      n_total++;
      $display("FAIL %s: expectation for cycle %0d never compared, now cycle %0d",
               sb[0].name, sb[0].cyc, cyc);
      sb.delete(0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
